auto_command_generator: RTL and testbench
=========================================

# auto_command_generator

Autopilot front end for the semi-automatic driving controller. It watches the controller's state and the four obstacle detectors, picks a direction with a right-hand wall-following rule, and drives the controller's command inputs (go_straight_command, turn_left_command, turn_right_command) with timed pulses. It sits between the detector bank and the semi-auto controller, replacing the manual command switches in auto mode, and uses the controller's state change as its acknowledge.

## Interface
- PULSE_CYCLES, default 4: width of every command pulse in clocks (legal 1..255).
- SETTLE_CYCLES, default 8: clocks the detector vector must be unchanged before a decision (legal 1..255).
- ACK_TIMEOUT, default 64: clocks allowed after a pulse ends for the controller to leave WAIT (legal 1..65535).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  autopilot on; sampled in IDLE only.
- front_detector, back_detector, left_detector, right_detector  in  1 each  1 = obstacle, 0 = open.
- state  in  2  controller state: 2'b00 stopped, 2'b01 forward, 2'b10 turning, 2'b11 WAIT (needs a command).
- go_straight_command, turn_left_command, turn_right_command  out  1 each  one-hot command pulses to the controller.
- busy  out  1  high in any state except IDLE.
- stuck  out  1  sticky: dead end (all four detectors blocked).
- error  out  1  sticky: acknowledge timeout.

## Operation
- FSM states: IDLE, SETTLE, DECIDE, PULSE, ACK, GAP.
- IDLE → SETTLE when enable=1 and state==2'b11. Clear the settle counter and latch the detector vector.
- SETTLE: each clock, compare the detectors with the latched vector.
  - Any difference: re-latch the vector and clear the counter.
  - Counter reaches SETTLE_CYCLES-1 with no difference: go to DECIDE.
  - state leaves 2'b11 during SETTLE: return to IDLE and issue nothing.
- DECIDE (1 clock), priority order:
  - right open: turn right.
  - else front open: go straight.
  - else left open: turn left.
  - else back open: U-turn, which is turn right with the uturn_pending flag set.
  - else (all blocked): set stuck and return to IDLE.
- PULSE: assert exactly one command output for PULSE_CYCLES clocks, then go to ACK.
- ACK: wait for state != 2'b11, counting clocks.
  - Counter hits ACK_TIMEOUT: set error, clear uturn_pending, go to IDLE.
  - Ack with uturn_pending=1: clear uturn_pending and go to GAP.
  - Ack with uturn_pending=0: go to IDLE.
- GAP: wait for state==2'b11 again, then go straight to PULSE with turn right. The second half of a U-turn skips SETTLE and DECIDE.
- enable is ignored outside IDLE; a decision in progress always completes.
- stuck and error stay set until rst. Neither blocks further operation.
- Counters are 8 bits (settle, pulse) and 16 bits (ack). Counts saturate and never wrap.

## Timing
- Reset values: all command outputs 0, busy 0, stuck 0, error 0, FSM in IDLE, uturn_pending 0, counters 0.
- All outputs are registered. Commands change only on a clock edge and are never asserted two at a time.
- Latency with stable detectors: WAIT seen in IDLE at edge N; first command-high cycle is edge N+SETTLE_CYCLES+2 (1 IDLE→SETTLE, SETTLE_CYCLES settle, 1 DECIDE).
- The command is high for exactly PULSE_CYCLES clocks. The ACK count starts on the first clock after the pulse falls.
- Simultaneous events:
  - state leaves WAIT in the same clock that the SETTLE count completes: the state exit wins (return to IDLE).
  - Ack arrives in the same clock that the count hits ACK_TIMEOUT: the ack wins (no error).
- A state change during PULSE does not shorten the pulse. The ack is checked only in ACK; an early state exit is still seen there if it persists.
- rst mid-pulse drops the command on the next edge.

## Test plan
- Corridor: front=0, left=1, right=1, back=0, state=2'b11, enable=1. go_straight_command goes high at cycle SETTLE_CYCLES+2 for 4 clocks. state set to 2'b01 → busy low 1 clock later.
- Right opening: front=0, left=1, right=0. Only turn_right_command pulses, for 4 clocks.
- Bounce: toggle right_detector every 3 clocks for 20 clocks, then hold. No command until 8 stable clocks have passed; the decision uses the final value.
- U-turn: front, left, right =1, back=0. Two turn_right pulses, separated by state going 2'b10 then back to 2'b11. uturn_pending is clear afterwards.
- Dead end: all detectors 1. No command; stuck=1, busy returns to 0, stuck holds until rst.
- Timeout and reset: state held at 2'b11 after a pulse. error=1 after exactly 64 clocks in ACK. A second run with rst asserted mid-PULSE: all outputs 0 on the next edge.

Source files
------------

// File: rtl/auto_command_generator.sv
// auto_command_generator
// Autopilot front end for the semi-automatic driving controller. When the
// controller sits in WAIT it lets the detector vector settle, picks a
// direction with a right-hand wall-following rule and issues one timed
// command pulse, then uses the controller leaving WAIT as its acknowledge.
// A U-turn is two right-turn pulses; the second one skips settle/decide.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   enable                   autopilot on, sampled in IDLE only
//   *_detector               1 = obstacle, 0 = open
//   state[1:0]               controller state, 2'b11 = WAIT (needs a command)
//   go_straight_command,
//   turn_left_command,
//   turn_right_command       one-hot registered command pulses
//   busy                     high whenever the FSM is not in IDLE
//   stuck                    sticky: dead end seen (all four detectors blocked)
//   error                    sticky: acknowledge timeout
module auto_command_generator #(
  parameter int PULSE_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int ACK_TIMEOUT   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       front_detector,
  input  logic       back_detector,
  input  logic       left_detector,
  input  logic       right_detector,
  input  logic [1:0] state,
  output logic       go_straight_command,
  output logic       turn_left_command,
  output logic       turn_right_command,
  output logic       busy,
  output logic       stuck,
  output logic       error
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_DECIDE, S_PULSE, S_ACK, S_GAP
  } fsm_e;

  // Command encoding {go_straight, turn_left, turn_right}
  localparam logic [2:0] CMD_GO    = 3'b100;
  localparam logic [2:0] CMD_LEFT  = 3'b010;
  localparam logic [2:0] CMD_RIGHT = 3'b001;

  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0]  PULSE_LAST  = 8'(PULSE_CYCLES - 1);
  localparam logic [15:0] ACK_LAST    = 16'(ACK_TIMEOUT - 1);

  fsm_e        fsm_q, fsm_d;
  logic [3:0]  det_q, det_d;          // {front, back, left, right}
  logic [7:0]  settle_cnt_q, settle_cnt_d;
  logic [7:0]  pulse_cnt_q, pulse_cnt_d;
  logic [15:0] ack_cnt_q, ack_cnt_d;
  logic [2:0]  dir_q, dir_d;          // command chosen for the next pulse
  logic [2:0]  cmd_q, cmd_d;          // registered command outputs
  logic        uturn_q, uturn_d;
  logic        stuck_q, stuck_d;
  logic        error_q, error_d;
  logic        busy_q, busy_d;

  logic [3:0]  det;
  logic        wait_st;

  assign det     = {front_detector, back_detector, left_detector, right_detector};
  assign wait_st = (state == 2'b11);

  always_comb begin
    fsm_d        = fsm_q;
    det_d        = det_q;
    settle_cnt_d = settle_cnt_q;
    pulse_cnt_d  = pulse_cnt_q;
    ack_cnt_d    = ack_cnt_q;
    dir_d        = dir_q;
    uturn_d      = uturn_q;
    stuck_d      = stuck_q;
    error_d      = error_q;

    case (fsm_q)
      S_IDLE: begin
        if (enable && wait_st) begin
          fsm_d        = S_SETTLE;
          settle_cnt_d = '0;
          det_d        = det;
        end
      end
      S_SETTLE: begin
        // Leaving WAIT has priority over a completing settle count.
        if (!wait_st) begin
          fsm_d = S_IDLE;
        end else if (det != det_q) begin
          det_d        = det;
          settle_cnt_d = '0;
        end else if (settle_cnt_q == SETTLE_LAST) begin
          fsm_d = S_DECIDE;
        end else if (settle_cnt_q != 8'hFF) begin
          settle_cnt_d = settle_cnt_q + 8'd1;
        end
      end
      S_DECIDE: begin
        // Right-hand rule: right, front, left, then U-turn via back.
        fsm_d       = S_PULSE;
        pulse_cnt_d = '0;
        if (!det_q[0]) begin
          dir_d = CMD_RIGHT;
        end else if (!det_q[3]) begin
          dir_d = CMD_GO;
        end else if (!det_q[1]) begin
          dir_d = CMD_LEFT;
        end else if (!det_q[2]) begin
          dir_d   = CMD_RIGHT;
          uturn_d = 1'b1;
        end else begin
          stuck_d = 1'b1;
          fsm_d   = S_IDLE;
        end
      end
      S_PULSE: begin
        if (pulse_cnt_q == PULSE_LAST) begin
          fsm_d     = S_ACK;
          ack_cnt_d = '0;
        end else if (pulse_cnt_q != 8'hFF) begin
          pulse_cnt_d = pulse_cnt_q + 8'd1;
        end
      end
      S_ACK: begin
        // An ack in the same clock as the timeout wins.
        if (!wait_st) begin
          uturn_d = 1'b0;
          fsm_d   = uturn_q ? S_GAP : S_IDLE;
        end else if (ack_cnt_q == ACK_LAST) begin
          error_d = 1'b1;
          uturn_d = 1'b0;
          fsm_d   = S_IDLE;
        end else if (ack_cnt_q != 16'hFFFF) begin
          ack_cnt_d = ack_cnt_q + 16'd1;
        end
      end
      S_GAP: begin
        // Second half of a U-turn: straight back to a right pulse.
        if (wait_st) begin
          dir_d       = CMD_RIGHT;
          pulse_cnt_d = '0;
          fsm_d       = S_PULSE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase

    // Outputs follow the next state so they are registered and aligned.
    cmd_d  = (fsm_d == S_PULSE) ? dir_d : 3'b000;
    busy_d = (fsm_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q        <= S_IDLE;
      det_q        <= '0;
      settle_cnt_q <= '0;
      pulse_cnt_q  <= '0;
      ack_cnt_q    <= '0;
      dir_q        <= '0;
      cmd_q        <= '0;
      uturn_q      <= 1'b0;
      stuck_q      <= 1'b0;
      error_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      det_q        <= det_d;
      settle_cnt_q <= settle_cnt_d;
      pulse_cnt_q  <= pulse_cnt_d;
      ack_cnt_q    <= ack_cnt_d;
      dir_q        <= dir_d;
      cmd_q        <= cmd_d;
      uturn_q      <= uturn_d;
      stuck_q      <= stuck_d;
      error_q      <= error_d;
      busy_q       <= busy_d;
    end
  end

  assign go_straight_command = cmd_q[2];
  assign turn_left_command   = cmd_q[1];
  assign turn_right_command  = cmd_q[0];
  assign busy                = busy_q;
  assign stuck               = stuck_q;
  assign error               = error_q;

endmodule

// File: tb/tb_auto_command_generator.sv
// Scoreboard bench for auto_command_generator: stimulus pushes the expected
// pulse (command and edge at which it is first seen high) into a queue; a
// monitor sampling 1 time unit after each rising edge pops and compares
// every pulse it observes and checks its width.
module tb_auto_command_generator;
  localparam int S = 8;
  localparam int P = 4;
  localparam int T = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       fd = 1'b0, bd = 1'b0, ld = 1'b0, rd = 1'b0;
  logic [1:0] st = 2'b00;
  logic       go, tl, tr, busy, stuck, error;
  logic [2:0] cmds;

  assign cmds = {go, tl, tr};

  auto_command_generator #(
    .PULSE_CYCLES(P), .SETTLE_CYCLES(S), .ACK_TIMEOUT(T)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .front_detector(fd), .back_detector(bd),
    .left_detector(ld), .right_detector(rd),
    .state(st),
    .go_straight_command(go), .turn_left_command(tl), .turn_right_command(tr),
    .busy(busy), .stuck(stuck), .error(error)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0] cmd;
    int         lo;
    int         hi;
  } exp_t;
  exp_t expq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Monitor: pulse start, command identity, timing and width.
  initial begin
    logic [2:0] cur;
    int         width;
    logic       inp;
    exp_t       x;
    inp = 1'b0; width = 0; cur = 3'b000;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        inp = 1'b0;
      end else if (!inp && cmds != 3'b000) begin
        inp = 1'b1; width = 1; cur = cmds;
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got cmd %b at edge %0d, expected none", cmds, edge_cnt);
        end else begin
          x = expq.pop_front();
          if (cmds !== x.cmd || edge_cnt < x.lo || edge_cnt > x.hi) begin
            errors++;
            $display("FAIL pulse_start: got cmd %b at edge %0d, expected cmd %b at edge %0d..%0d",
                     cmds, edge_cnt, x.cmd, x.lo, x.hi);
          end
        end
      end else if (inp && cmds == 3'b000) begin
        inp = 1'b0;
        chk("pulse_width", width, P);
      end else if (inp) begin
        width++;
        if (cmds !== cur) begin
          checks++; errors++;
          $display("FAIL pulse_stable: got cmd %b expected %b at edge %0d", cmds, cur, edge_cnt);
        end
      end
    end
  end

  // Present a WAIT with the given detectors for one enable clock.
  task automatic go_wait(input logic f, input logic b, input logic l, input logic r,
                         input logic [2:0] exp_cmd, output int e);
    @(negedge clk);
    fd = f; bd = b; ld = l; rd = r;
    st = 2'b11; enable = 1'b1;
    e = edge_cnt;
    if (exp_cmd != 3'b000) expq.push_back('{cmd: exp_cmd, lo: e + S + 2, hi: e + S + 2});
    @(negedge clk);
    enable = 1'b0;
  endtask

  // Wait (bounded) for a pulse to rise and fall; f = edge count at the fall.
  task automatic wait_fall(output int f);
    logic seen;
    seen = 1'b0;
    f = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmds != 3'b000) seen = 1'b1;
      else if (seen) begin
        f = edge_cnt;
        break;
      end
    end
    if (f < 0) begin
      checks++; errors++;
      $display("FAIL pulse_timeout: got no complete pulse within 200 clocks, expected one");
    end
  endtask

  initial begin
    int e, f, f2, last;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cmds", cmds, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stuck", stuck, 0);
    chk("rst_error", error, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // Corridor: straight, exact latency, busy drops one clock after ack
    go_wait(1'b0, 1'b0, 1'b1, 1'b1, 3'b100, e);
    repeat (S) @(negedge clk);
    chk("corr_busy_decide", busy, 1);
    chk("corr_cmd_pre", cmds, 0);
    wait_fall(f);
    chk("corr_fall_edge", f, e + S + 2 + P);
    chk("corr_busy_ack", busy, 1);
    st = 2'b01;
    @(negedge clk);
    chk("corr_busy_done", busy, 0);

    // Right opening takes priority over front
    go_wait(1'b0, 1'b0, 1'b1, 1'b0, 3'b001, e);
    wait_fall(f);
    st = 2'b01;
    @(negedge clk);
    chk("right_busy_done", busy, 0);

    // Bounce on right detector; decision waits for the final stable value
    go_wait(1'b1, 1'b0, 1'b1, 1'b1, 3'b000, e);
    last = edge_cnt;
    for (int i = 0; i < 20; i++) begin
      if (i % 3 == 0) begin
        rd = ~rd;
        last = edge_cnt;
      end
      @(negedge clk);
    end
    expq.push_back('{cmd: 3'b001, lo: last + S + 2, hi: last + S + 2});
    wait_fall(f);
    st = 2'b01;
    @(negedge clk);

    // U-turn: two right pulses around a turning phase
    go_wait(1'b1, 1'b0, 1'b1, 1'b1, 3'b001, e);
    wait_fall(f);
    st = 2'b10;
    @(negedge clk);
    chk("uturn_gap_busy", busy, 1);
    st = 2'b11;
    expq.push_back('{cmd: 3'b001, lo: f + 2, hi: f + 2});
    wait_fall(f2);
    chk("uturn_second_fall", f2, f + 2 + P);
    st = 2'b01;
    @(negedge clk);
    chk("uturn_cleared_idle", busy, 0);

    // Dead end: no command, stuck sets and holds
    go_wait(1'b1, 1'b1, 1'b1, 1'b1, 3'b000, e);
    repeat (S) @(negedge clk);
    chk("dead_busy_decide", busy, 1);
    chk("dead_stuck_pre", stuck, 0);
    @(negedge clk);
    chk("dead_stuck", stuck, 1);
    chk("dead_busy", busy, 0);
    repeat (20) @(negedge clk);
    chk("dead_stuck_hold", stuck, 1);
    chk("dead_busy_hold", busy, 0);

    // Ack timeout: error after exactly T clocks in ACK, stuck does not block
    go_wait(1'b0, 1'b0, 1'b1, 1'b1, 3'b100, e);
    wait_fall(f);
    repeat (T - 1) @(negedge clk);
    chk("tmo_error_pre", error, 0);
    chk("tmo_busy_pre", busy, 1);
    @(negedge clk);
    chk("tmo_error", error, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_stuck_kept", stuck, 1);

    // Reset mid-pulse clears everything on the next edge
    go_wait(1'b0, 1'b0, 1'b1, 1'b1, 3'b100, e);
    repeat (S + 2) @(negedge clk);
    chk("rstp_cmd_high", cmds, 3'b100);
    rst = 1'b1;
    @(negedge clk);
    chk("rstp_cmds", cmds, 0);
    chk("rstp_busy", busy, 0);
    chk("rstp_stuck", stuck, 0);
    chk("rstp_error", error, 0);
    st = 2'b01;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    chk("queue_empty", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish within 200000 time units, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
